// File: rtl/trace_line_writer.sv
// Serialises one cache trace record into the ASCII line "<op> <hex addr>\n", one byte per valid/ready beat.
// Define TRACE_ZERO_SUPPRESS_EN to drop leading zero hex digits. An all-zero address still emits a single "0".
module trace_line_writer #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_byte,
    output logic                  out_last,
    output logic                  busy,
    output logic                  bad_op,
    output logic [CNT_WIDTH-1:0]  line_count
);

    localparam int NIB   = ADDR_WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [2:0] {IDLE, OP, SP, HEX, NL} state_t;

    state_t                state, state_nxt;
    logic [3:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [IDX_W-1:0]      nib_idx;
    logic [IDX_W-1:0]      nib_start;
    logic [3:0]            cur_nib;
    logic                  in_fire;
    logic                  out_fire;
    logic                  op_legal;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign op_legal = (in_op <= 4'd9);

    always_comb begin
        cur_nib = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            if (nib_idx == IDX_W'(i)) cur_nib = addr_q[i*4 +: 4];
        end
    end

    // The highest non-zero nibble wins because the scan runs upward.
`ifdef TRACE_ZERO_SUPPRESS_EN
    always_comb begin
        nib_start = '0;
        for (int i = 0; i < NIB; i++) begin
            if (addr_q[i*4 +: 4] != 4'h0) nib_start = IDX_W'(i);
        end
    end
`else
    assign nib_start = IDX_W'(NIB - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_fire && op_legal)             state_nxt = OP;
            OP:   if (out_fire)                        state_nxt = SP;
            SP:   if (out_fire)                        state_nxt = HEX;
            HEX:  if (out_fire && nib_idx == '0)       state_nxt = NL;
            NL:   if (out_fire)                        state_nxt = IDLE;
            default:                                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state != IDLE);
        out_last  = (state == NL);
        out_byte  = 8'h00;
        case (state)
            OP:  out_byte = 8'h30 + {4'h0, op_q};
            SP:  out_byte = 8'h20;
            HEX: out_byte = (cur_nib < 4'd10) ? (8'h30 + {4'h0, cur_nib})
                                              : (8'h57 + {4'h0, cur_nib});
            NL:  out_byte = 8'h0A;
            default: out_byte = 8'h00;
        endcase
    end

    // An illegal op is consumed in IDLE without ever leaving it, so only the pulse records it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= 4'h0;
            addr_q     <= '0;
            nib_idx    <= '0;
            bad_op     <= 1'b0;
            line_count <= '0;
        end else begin
            bad_op <= in_fire && !op_legal;
            if (in_fire && op_legal) begin
                op_q   <= in_op;
                addr_q <= in_addr;
            end
            if (state == SP && out_fire) begin
                nib_idx <= nib_start;
            end else if (state == HEX && out_fire && nib_idx != '0) begin
                nib_idx <= nib_idx - 1'b1;
            end
            if (state == NL && out_fire) begin
                line_count <= line_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trace_line_writer.sv
// Directed bench for trace_line_writer: table of records with hand-computed byte lines, plus
// back-to-back, mid-line reset and counter-wrap sequences (a 2-bit-counter twin shows the wrap).
module tb_trace_line_writer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        busy;
    logic        bad_op;
    logic [15:0] line_count;

    logic        in_ready2;
    logic        out_valid2;
    logic [7:0]  out_byte2;
    logic        out_last2;
    logic        busy2;
    logic        bad_op2;
    logic [1:0]  line_count2;

    int n_cmp;
    int n_fail;
    int exp_lines;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] addr;
        logic        toggle;
        logic        bad;
        logic [3:0]  len;
        logic [95:0] bytes;
    } vec_t;

    vec_t vecs [7];
    vec_t extra;

    trace_line_writer #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_addr(in_addr), .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_last(out_last), .busy(busy), .bad_op(bad_op),
        .line_count(line_count)
    );

    trace_line_writer #(.ADDR_WIDTH(32), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_op(in_op), .in_addr(in_addr), .out_valid(out_valid2), .out_ready(out_ready),
        .out_byte(out_byte2), .out_last(out_last2), .busy(busy2), .bad_op(bad_op2),
        .line_count(line_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drains one line; bytes are left-justified in the 96-bit vector.
    task automatic drainLine(input logic [95:0] bytes, input int len, input logic toggle);
        int         idx;
        int         cyc;
        logic       stalled;
        logic [8:0] held;
        idx     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        out_ready = !toggle;
        while (idx < len && cyc < 64) begin
            @(negedge clk);
            cyc++;
            checkOutput("out_valid_in_line", {31'b0, out_valid}, 32'd1);
            checkOutput("in_ready_in_line", {31'b0, in_ready}, 32'd0);
            if (stalled) checkOutput("hold_byte", {23'b0, out_last, out_byte}, {23'b0, held});
            if (out_ready) begin
                checkOutput("line_byte", {24'b0, out_byte}, {24'b0, bytes[95 - 8*idx -: 8]});
                checkOutput("out_last", {31'b0, out_last}, {31'b0, (idx == len - 1)});
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = {out_last, out_byte};
            end
            @(posedge clk);
            #1;
            if (toggle) out_ready = ~out_ready;
        end
        if (idx < len) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL line_timeout: got %0d bytes, expected %0d", idx, len);
        end
        if (!toggle) checkOutput("line_cycles", cyc, len);
        out_ready = 1'b1;
    endtask

    task automatic checkIdle();
        @(negedge clk);
        checkOutput("line_count", {16'b0, line_count}, exp_lines);
        checkOutput("line_count_small", {30'b0, line_count2}, exp_lines & 3);
        checkOutput("in_ready_idle", {31'b0, in_ready}, 32'd1);
        checkOutput("busy_idle", {31'b0, busy}, 32'd0);
        checkOutput("out_valid_idle", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        checkOutput("in_ready_before", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_op    = v.op;
        in_addr  = v.addr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (v.bad) begin
            @(negedge clk);
            checkOutput("bad_op_pulse", {31'b0, bad_op}, 32'd1);
            checkOutput("bad_no_valid", {31'b0, out_valid}, 32'd0);
            @(negedge clk);
            checkOutput("bad_op_clear", {31'b0, bad_op}, 32'd0);
        end else begin
            exp_lines++;
            drainLine(v.bytes, int'(v.len), v.toggle);
        end
        checkIdle();
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        exp_lines = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'h0;
        in_addr   = 32'h0;
        out_ready = 1'b1;

`ifdef TRACE_ZERO_SUPPRESS_EN
        vecs[0] = '{op:4'd2, addr:32'h0000_1A3F, toggle:1'b0, bad:1'b0, len:4'd7,
                    bytes:96'h32_20_31_61_33_66_0A_00_00_00_00_00};
        vecs[1] = '{op:4'd2, addr:32'h0000_1A3F, toggle:1'b1, bad:1'b0, len:4'd7,
                    bytes:96'h32_20_31_61_33_66_0A_00_00_00_00_00};
        vecs[6] = '{op:4'd7, addr:32'h0000_0001, toggle:1'b1, bad:1'b0, len:4'd4,
                    bytes:96'h37_20_31_0A_00_00_00_00_00_00_00_00};
`else
        vecs[0] = '{op:4'd2, addr:32'h0000_1A3F, toggle:1'b0, bad:1'b0, len:4'd11,
                    bytes:96'h32_20_30_30_30_30_31_61_33_66_0A_00};
        vecs[1] = '{op:4'd2, addr:32'h0000_1A3F, toggle:1'b1, bad:1'b0, len:4'd11,
                    bytes:96'h32_20_30_30_30_30_31_61_33_66_0A_00};
        vecs[6] = '{op:4'd7, addr:32'h0000_0001, toggle:1'b1, bad:1'b0, len:4'd11,
                    bytes:96'h37_20_30_30_30_30_30_30_30_31_0A_00};
`endif
        vecs[2] = '{op:4'd12, addr:32'hDEAD_BEEF, toggle:1'b0, bad:1'b1, len:4'd0, bytes:96'h0};
        vecs[3] = '{op:4'd9, addr:32'hFFFF_FFFF, toggle:1'b0, bad:1'b0, len:4'd11,
                    bytes:96'h39_20_66_66_66_66_66_66_66_66_0A_00};
        vecs[4] = '{op:4'd5, addr:32'h89AB_CDE0, toggle:1'b0, bad:1'b0, len:4'd11,
                    bytes:96'h35_20_38_39_61_62_63_64_65_30_0A_00};
        vecs[5] = '{op:4'd15, addr:32'h0000_0042, toggle:1'b0, bad:1'b1, len:4'd0, bytes:96'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_byte", {24'b0, out_byte}, 32'h00);
        checkOutput("rst_out_last", {31'b0, out_last}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_bad_op", {31'b0, bad_op}, 32'd0);
        checkOutput("rst_line_count", {16'b0, line_count}, 32'd0);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Back-to-back: the second record must be taken on the single IDLE cycle.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_addr  = 32'h0000_0010;
        @(posedge clk);
        #1;
        in_op   = 4'd1;
        in_addr = 32'h0000_0020;
        exp_lines++;
`ifdef TRACE_ZERO_SUPPRESS_EN
        drainLine(96'h30_20_31_30_0A_00_00_00_00_00_00_00, 5, 1'b0);
`else
        drainLine(96'h30_20_30_30_30_30_30_30_31_30_0A_00, 11, 1'b0);
`endif
        @(negedge clk);
        checkOutput("b2b_gap_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("b2b_gap_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_lines++;
`ifdef TRACE_ZERO_SUPPRESS_EN
        drainLine(96'h31_20_32_30_0A_00_00_00_00_00_00_00, 5, 1'b0);
`else
        drainLine(96'h31_20_30_30_30_30_30_30_32_30_0A_00, 11, 1'b0);
`endif
        checkIdle();

        // Asynchronous reset four bytes into a line.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 4'd4;
        in_addr  = 32'h1234_5678;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mid_line_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_lines = 0;
        checkOutput("async_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("async_busy", {31'b0, busy}, 32'd0);
        checkOutput("async_line_count", {16'b0, line_count}, 32'd0);
        checkOutput("async_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        checkOutput("held_rst_valid", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b1;

`ifdef TRACE_ZERO_SUPPRESS_EN
        extra = '{op:4'd3, addr:32'h0, toggle:1'b0, bad:1'b0, len:4'd4,
                  bytes:96'h33_20_30_0A_00_00_00_00_00_00_00_00};
`else
        extra = '{op:4'd3, addr:32'h0, toggle:1'b0, bad:1'b0, len:4'd11,
                  bytes:96'h33_20_30_30_30_30_30_30_30_30_0A_00};
`endif
        applyStimulus(extra);

        // Three more lines bring the 2-bit counter to all-ones and then through the wrap.
        applyStimulus(vecs[3]);
        applyStimulus(vecs[4]);
        checkOutput("small_count_all_ones", {30'b0, line_count2}, 32'd3);
        applyStimulus(vecs[0]);
        checkOutput("small_count_wrap", {30'b0, line_count2}, 32'd0);
        checkOutput("count_after_wrap", {16'b0, line_count}, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

endmodule
